// File: rtl/srff.sv
// Parameterised bank of independent, clocked SR bit-cells.
// Each bit holds on (0,0), clears on (0,1) and sets on (1,0). The S=R=1
// policy is chosen by BOTH_MODE. q_bar is a combinational complement of the
// state register, so q and q_bar can never agree.
module srff #(
    parameter int WIDTH     = 1,
    // S=R=1 policy: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
    // Any other value is treated as reset-dominant.
    parameter int BOTH_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] invalid
);

    // Out-of-range policy values collapse to reset-dominant.
    localparam int MODE = (BOTH_MODE >= 0 && BOTH_MODE <= 3) ? BOTH_MODE : 0;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] invalid_next;

    // Next value of one bit when both set and reset are requested.
    function automatic logic resolve_both(input logic cur);
        case (MODE)
            1:       return 1'b1;
            2:       return cur;
            3:       return ~cur;
            default: return 1'b0;
        endcase
    endfunction

    // Per-bit next-state decode; bits never look at each other.
    always_comb begin
        q_next       = q;
        invalid_next = s & r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11:   q_next[i] = resolve_both(q[i]);
                default: q_next[i] = q[i];
            endcase
        end
    end

    // State and conflict-flag registers; synchronous reset wins over s/r.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            invalid <= '0;
        end else begin
            q       <= q_next;
            invalid <= invalid_next;
        end
    end

    // The complement comes from the same register, never a second flop.
    assign q_bar = ~q;

endmodule

// File: tb/tb_srff.sv
// Testbench for srff: five 4-bit instances sharing s/r/rst, one per S=R=1
// policy (0..3) plus an out-of-range policy value that must act like 0.
module tb_srff;

    localparam int W  = 4;
    localparam int ND = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] s   = '0;
    logic [W-1:0] r   = '0;

    logic [W-1:0] q_o   [ND];
    logic [W-1:0] qb_o  [ND];
    logic [W-1:0] inv_o [ND];

    // Policy each instance implements, as the reference model sees it.
    int mode_of [ND] = '{0, 1, 2, 3, 0};

    // Reference state per instance.
    logic [W-1:0] mq   [ND];
    logic [W-1:0] minv [ND];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        srff #(
            .WIDTH    (W),
            .BOTH_MODE((g == 4) ? 7 : g)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s      (s),
            .r      (r),
            .q      (q_o[g]),
            .q_bar  (qb_o[g]),
            .invalid(inv_o[g])
        );
    end

    // Behavioural model: apply the truth table of an SR cell to every bit.
    task automatic model_edge(input logic rs, input logic [W-1:0] ss, input logic [W-1:0] rr);
        for (int d = 0; d < ND; d++) begin
            if (rs) begin
                mq[d]   = '0;
                minv[d] = '0;
            end else begin
                for (int b = 0; b < W; b++) begin
                    if (ss[b] && !rr[b])      mq[d][b] = 1'b1;
                    else if (!ss[b] && rr[b]) mq[d][b] = 1'b0;
                    else if (ss[b] && rr[b]) begin
                        if (mode_of[d] == 1)      mq[d][b] = 1'b1;
                        else if (mode_of[d] == 2) mq[d][b] = mq[d][b];
                        else if (mode_of[d] == 3) mq[d][b] = !mq[d][b];
                        else                      mq[d][b] = 1'b0;
                    end
                    minv[d][b] = ss[b] && rr[b];
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Compare every instance against the model.
    task automatic check_all(input string tag);
        for (int d = 0; d < ND; d++) begin
            cmp($sformatf("%s q[dut%0d]", tag, d), q_o[d], mq[d]);
            cmp($sformatf("%s q_bar[dut%0d]", tag, d), qb_o[d], ~mq[d]);
            cmp($sformatf("%s invalid[dut%0d]", tag, d), inv_o[d], minv[d]);
        end
    endtask

    // Drive one edge's worth of inputs, clock it, then sample 1 ns later.
    task automatic step(input logic rs, input logic [W-1:0] ss, input logic [W-1:0] rr);
        rst = rs;
        s   = ss;
        r   = rr;
        @(posedge clk);
        model_edge(rs, ss, rr);
        #1;
    endtask

    typedef struct {
        string        name;
        logic         rst;
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] q;    // expected q of the reset-dominant instance
        logic [W-1:0] inv;  // expected invalid of the reset-dominant instance
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{"rst_with_set",   1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{"hold_zero",      1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{"reset_req",      1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[3]  = '{"set_req",        1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        tbl[4]  = '{"hold_one",       1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[5]  = '{"set_all",        1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        tbl[6]  = '{"both_from_one",  1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tbl[7]  = '{"idle_after",     1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{"load_1010",      1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
        tbl[9]  = '{"mixed_bits",     1'b0, 4'b0011, 4'b0101, 4'b1010, 4'b0001};
        tbl[10] = '{"set_again",      1'b0, 4'b0110, 4'b0000, 4'b1110, 4'b0000};
        tbl[11] = '{"rst_over_both",  1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000};

        // Table vectors: fixed expectations for the reset-dominant instance
        // plus model checks for all policies.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].s, tbl[i].r);
            cmp({tbl[i].name, " q"}, q_o[0], tbl[i].q);
            cmp({tbl[i].name, " q_bar"}, qb_o[0], ~tbl[i].q);
            cmp({tbl[i].name, " invalid"}, inv_o[0], tbl[i].inv);
            check_all(tbl[i].name);
        end

        // Toggle policy: from q=0, hold S=R=1 for three edges.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b0, 4'b1111, 4'b1111);
        cmp("toggle1 q", q_o[3], 4'b1111);
        cmp("toggle1 invalid", inv_o[3], 4'b1111);
        check_all("toggle1");
        step(1'b0, 4'b1111, 4'b1111);
        cmp("toggle2 q", q_o[3], 4'b0000);
        cmp("toggle2 invalid", inv_o[3], 4'b1111);
        check_all("toggle2");
        step(1'b0, 4'b1111, 4'b1111);
        cmp("toggle3 q", q_o[3], 4'b1111);
        cmp("toggle3 invalid", inv_o[3], 4'b1111);
        cmp("set_dom q", q_o[1], 4'b1111);
        cmp("hold_pol q", q_o[2], 4'b0000);
        cmp("oor_mode q", q_o[4], 4'b0000);
        check_all("toggle3");
        step(1'b0, 4'b0000, 4'b0000);
        check_all("toggle_idle");

        // Inputs and rst wiggle between edges: nothing may change until the
        // next edge, and that edge sees only the final (idle) inputs.
        step(1'b0, 4'b0101, 4'b0000);
        #1 s = 4'b1111; r = 4'b0000;
        #1 rst = 1'b1;
        #1 rst = 1'b0; s = 4'b0000; r = 4'b1111;
        #1 s = 4'b0000; r = 4'b0000;
        check_all("between_edges");
        step(1'b0, 4'b0000, 4'b0000);
        check_all("after_glitch");

        // Reset in the middle of activity, then normal behaviour resumes.
        step(1'b0, 4'b1100, 4'b0011);
        step(1'b1, 4'b1111, 4'b0000);
        check_all("mid_rst");
        step(1'b0, 4'b1001, 4'b0000);
        check_all("post_rst");

        // Randomised traffic checked against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0),
                 W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)));
            check_all($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
